// File: rtl/mem_lsu_initiator_pkg.sv
// Shared encodings for the LSU initiator: access sizes, completion error codes, FSM states.
package mem_lsu_initiator_pkg;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_ERR} state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_initiator_lane_align.sv
// Byte-lane steering: store mask/replicated data, and load shift plus sign/zero extension.
module lsu_lane_align
  import mem_lsu_initiator_pkg::*;
(
  input  logic [1:0]  wr_off,
  input  logic [1:0]  wr_size,
  input  logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  rd_off,
  input  logic [1:0]  rd_size,
  input  logic        rd_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    wmask     = 4'hF;
    wdata_rep = wdata;
    case (wr_size)
      SZ_B: begin
        wmask     = 4'b0001 << wr_off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        wmask     = 4'b0011 << wr_off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {rd_off, 3'b000};
    rdata_ext = shifted;
    case (rd_size)
      SZ_B: rdata_ext = rd_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: rdata_ext = rd_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu_initiator.sv
// One-at-a-time load/store initiator for a word memory port with alignment checks and a
// bounded wait for read responses; completion is reported as a one-cycle done pulse.
module mem_lsu_initiator
  import mem_lsu_initiator_pkg::*;
#(
  parameter int CPU_WIDTH      = 32,
  parameter int ADDR_BITS      = 32,
  parameter int WORD_ADDR_BITS = ADDR_BITS - $clog2(CPU_WIDTH / 8),
  parameter int RESP_TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [ADDR_BITS-1:0]      op_addr,
  input  logic [CPU_WIDTH-1:0]      op_wdata,
  input  logic                      op_store,
  input  logic [1:0]                op_size,
  input  logic                      op_unsigned,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_data,
  output logic [3:0]                mem_req_write,
  input  logic                      mem_resp_valid,
  input  logic [CPU_WIDTH-1:0]      mem_resp_data,
  output logic                      done_valid,
  output logic [CPU_WIDTH-1:0]      done_rdata,
  output logic [1:0]                done_err
);

  localparam int CNT_W = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             store_q;
  logic [3:0]       wmask;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;

  lsu_lane_align u_align (
    .wr_off      (op_addr[1:0]),
    .wr_size     (op_size),
    .wdata       (op_wdata),
    .wmask       (wmask),
    .wdata_rep   (wdata_rep),
    .rd_off      (off_q),
    .rd_size     (size_q),
    .rd_unsigned (uns_q),
    .rdata       (mem_resp_data),
    .rdata_ext   (rdata_ext)
  );

  // Gated by reset so every output reads 0 while reset is held.
  assign op_ready = reset && (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      store_q       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_write <= '0;
      done_valid    <= 1'b0;
      done_rdata    <= '0;
      done_err      <= ERR_NONE;
    end else begin
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            off_q   <= op_addr[1:0];
            size_q  <= op_size;
            uns_q   <= op_unsigned;
            store_q <= op_store;
            if (op_size == SZ_ILL || misaligned(op_size, op_addr[1:0])) begin
              // Error completion is reported straight away; ERR only spends the pulse cycle.
              state      <= ST_ERR;
              done_valid <= 1'b1;
              done_rdata <= '0;
              done_err   <= (op_size == SZ_ILL) ? ERR_ILLEGAL : ERR_MISALIGN;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= op_addr[ADDR_BITS-1 -: WORD_ADDR_BITS];
              mem_req_data  <= op_store ? wdata_rep : '0;
              mem_req_write <= op_store ? wmask : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (store_q) begin
              state      <= ST_IDLE;
              done_valid <= 1'b1;
              done_rdata <= '0;
              done_err   <= ERR_NONE;
            end else begin
              state <= ST_WAIT;
              cnt   <= '0;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp_valid) begin
            state      <= ST_IDLE;
            done_valid <= 1'b1;
            done_rdata <= rdata_ext;
            done_err   <= ERR_NONE;
          end else if ((RESP_TIMEOUT != 0) && (cnt == CNT_W'(RESP_TIMEOUT - 1))) begin
            state      <= ST_IDLE;
            done_valid <= 1'b1;
            done_rdata <= '0;
            done_err   <= ERR_TIMEOUT;
          end
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_initiator.sv
// Bench for mem_lsu_initiator: directed vector table, reset-abort sequence, randomized ops vs model.
module tb_mem_lsu_initiator;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_write;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic [1:0]  done_err;

  int checks = 0;
  int passed = 0;

  mem_lsu_initiator #(.CPU_WIDTH(32), .ADDR_BITS(32), .RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_addr(op_addr), .op_wdata(op_wdata),
    .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .done_valid(done_valid), .done_rdata(done_rdata), .done_err(done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] resp;
    int          ready_dly;
    int          resp_dly;
    logic [1:0]  exp_err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte-count arithmetic on integers, independent of any lane-steering structure.
  function automatic void model(input logic [31:0] addr, input logic [31:0] wdata, input logic store,
                                input logic [1:0] size, input logic uns, input logic [31:0] resp,
                                input int resp_dly, output logic [1:0] err, output logic [3:0] mask,
                                output logic [31:0] data, output logic [31:0] rdata);
    longint n, off, v;
    n = 1 << size;
    off = addr % 4;
    err = 2'd0; mask = 4'd0; data = 32'd0; rdata = 32'd0;
    if (size == 2'd3) err = 2'd3;
    else if ((addr % n) != 0) err = 2'd1;
    else if (!store && resp_dly >= TMO) err = 2'd2;
    if (err != 2'd0) return;
    if (store) begin
      mask = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) data[8*i +: 8] = 8'((wdata >> (8 * (i % n))) & 8'hFF);
    end else begin
      v = (longint'(resp) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
      if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
      rdata = 32'(v);
    end
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    chk({tag, " op_ready_idle"}, op_ready, 1);
    op_valid = 1; op_addr = v.addr; op_wdata = v.wdata; op_store = v.store;
    op_size = v.size; op_unsigned = v.uns; mem_req_ready = 0;
    step();
    op_valid = 0;
    if (v.exp_err == 2'd1 || v.exp_err == 2'd3) begin
      chk({tag, " err_done"}, done_valid, 1);
      chk({tag, " err_code"}, done_err, v.exp_err);
      chk({tag, " err_rdata"}, done_rdata, 0);
      chk({tag, " err_no_req"}, mem_req_valid, 0);
      step();
      chk({tag, " err_pulse_end"}, done_valid, 0);
      return;
    end
    for (int k = 0; k <= v.ready_dly; k++) begin
      chk({tag, " req_valid"}, mem_req_valid, 1);
      chk({tag, " req_addr"}, mem_req_addr, v.addr >> 2);
      chk({tag, " req_write"}, mem_req_write, v.exp_mask);
      chk({tag, " req_data"}, mem_req_data, v.exp_data);
      chk({tag, " op_ready_busy"}, op_ready, 0);
      mem_req_ready = (k == v.ready_dly);
      step();
    end
    mem_req_ready = 0;
    chk({tag, " req_dropped"}, mem_req_valid, 0);
    if (v.store) begin
      chk({tag, " st_done"}, done_valid, 1);
      chk({tag, " st_err"}, done_err, 0);
      chk({tag, " st_rdata"}, done_rdata, 0);
      chk({tag, " st_op_ready"}, op_ready, 1);
      return;
    end
    for (int w = 0; w < TMO; w++) begin
      chk({tag, " wait_no_done"}, done_valid, 0);
      mem_resp_valid = (w == v.resp_dly);
      mem_resp_data = v.resp;
      step();
      if (mem_resp_valid || w == TMO - 1) begin
        mem_resp_valid = 0;
        chk({tag, " ld_done"}, done_valid, 1);
        chk({tag, " ld_err"}, done_err, v.exp_err);
        chk({tag, " ld_rdata"}, done_rdata, v.exp_rdata);
        chk({tag, " ld_op_ready"}, op_ready, 1);
        break;
      end
    end
    for (int w2 = TMO; w2 <= v.resp_dly; w2++) begin
      mem_resp_valid = (w2 == v.resp_dly);
      step();
      mem_resp_valid = 0;
      chk({tag, " late_resp_ignored"}, done_valid, 0);
    end
  endtask

  initial begin
    vec_t r;
    reset = 0; op_valid = 0; op_addr = 0; op_wdata = 0; op_store = 0; op_size = 0;
    op_unsigned = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    // addr, wdata, store, size, uns, resp, ready_dly, resp_dly, err, mask, data, rdata
    vecs[0]  = '{32'h1003, 32'h000000AB, 1, 2'd0, 0, 32'h0,        0, 0, 2'd0, 4'b1000, 32'hABABABAB, 32'h0};
    vecs[1]  = '{32'h2002, 32'h0,        0, 2'd1, 0, 32'h80011234, 0, 0, 2'd0, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[2]  = '{32'h2002, 32'h0,        0, 2'd1, 1, 32'h80011234, 0, 0, 2'd0, 4'b0000, 32'h0,        32'h00008001};
    vecs[3]  = '{32'h0006, 32'h0,        0, 2'd2, 0, 32'h0,        0, 0, 2'd1, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{32'h0010, 32'h0,        0, 2'd3, 0, 32'h0,        0, 0, 2'd3, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{32'h0020, 32'hDEADBEEF, 1, 2'd2, 0, 32'h0,        3, 0, 2'd0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{32'h0031, 32'h0,        0, 2'd0, 0, 32'h0000F700, 0, 2, 2'd0, 4'b0000, 32'h0,        32'hFFFFFFF7};
    vecs[7]  = '{32'h0040, 32'h0,        0, 2'd2, 0, 32'hCAFEF00D, 0, 3, 2'd0, 4'b0000, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{32'h0044, 32'h0,        0, 2'd2, 0, 32'h11111111, 0, 6, 2'd2, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{32'h0052, 32'h0000BEEF, 1, 2'd1, 0, 32'h0,        1, 0, 2'd0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[10] = '{32'h0053, 32'h0,        0, 2'd1, 0, 32'h0,        0, 0, 2'd1, 4'b0000, 32'h0,        32'h0};

    #12;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_data", mem_req_data, 0);
    chk("rst_req_write", mem_req_write, 0);
    chk("rst_done", {done_valid, done_err, done_rdata}, 0);
    reset = 1;
    step();
    chk("rst_op_ready", op_ready, 1);

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for a read response aborts the load.
    r = '{32'h0104, 32'h0, 0, 2'd2, 0, 32'h0, 0, 0, 2'd0, 4'b0, 32'h0, 32'h0};
    run_op(vecs[1], "pre_abort");
    op_valid = 1; op_addr = r.addr; op_size = 2'd2; op_store = 0; mem_req_ready = 1;
    step();
    op_valid = 0;
    step();
    mem_req_ready = 0;
    #2 reset = 0;
    #1;
    chk("abort_req_valid", mem_req_valid, 0);
    chk("abort_req_addr", mem_req_addr, 0);
    chk("abort_done", {done_valid, done_err, done_rdata}, 0);
    @(negedge clk) reset = 1;
    step();
    mem_resp_valid = 1; mem_resp_data = 32'h5A5A5A5A;
    step();
    mem_resp_valid = 0;
    chk("abort_stray_resp", done_valid, 0);
    step();
    chk("abort_stray_resp2", done_valid, 0);
    r.resp = 32'h0BADF00D; r.exp_rdata = 32'h0BADF00D; r.resp_dly = 1;
    run_op(r, "post_abort");

    for (int i = 0; i < 40; i++) begin
      r.addr = $urandom_range(0, 255);
      r.wdata = $urandom;
      r.store = 1'($urandom_range(0, 1));
      r.size = 2'($urandom_range(0, 3));
      r.uns = 1'($urandom_range(0, 1));
      r.resp = $urandom;
      r.ready_dly = $urandom_range(0, 2);
      r.resp_dly = $urandom_range(0, 5);
      model(r.addr, r.wdata, r.store, r.size, r.uns, r.resp, r.resp_dly,
            r.exp_err, r.exp_mask, r.exp_data, r.exp_rdata);
      run_op(r, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
